poly5_horner_ctrl: RTL and testbench

Sequential Horner-scheme controller that evaluates a 5th-degree fixed-point polynomial p(x) = c5·x⁵ + … + c0 using a single shared combinational 16s×16s→32 signed multiplier. It sits directly upstream of that multiplier: it drives both multiplier operands and consumes the 32-bit product every cycle. It presents an ap_start/ap_done block-level handshake to the poly5 top level.

---
 rtl/poly5_pkg.sv | 24 ++
 rtl/poly5_if.sv | 24 ++
 rtl/poly5_shift_add.sv | 38 +++
 rtl/poly5_horner_ctrl.sv | 72 +++++++
 tb/tb_poly5_horner_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly5_pkg.sv
// Shared types and helpers for the poly5 Horner controller.
// Contains the FSM state enum, the default Q-format widths and the saturate/wrap reduction.
package poly5_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  typedef logic [2:0] coef_idx_t;

  localparam coef_idx_t K_FIRST = 3'd4;

  // Reduces a wide signed value to w bits. With sat set it clamps to the w-bit
  // signed range; otherwise the caller's low w bits give two's-complement wrap.
  // Widths up to 32 bits are supported.
  function automatic logic signed [63:0] sat_wrap(input logic signed [64:0] v,
                                                  input int w, input logic sat);
    logic signed [64:0] hi, lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    sat_wrap = v[63:0];
    if (sat && (v > hi)) sat_wrap = hi[63:0];
    if (sat && (v < lo)) sat_wrap = lo[63:0];
  endfunction
endpackage

// File: rtl/poly5_if.sv
// Block-level handshake, operand/result bus and multiplier hookup of poly5_horner_ctrl.
// master = poly5 top level plus the shared multiplier, slave = the controller.
interface poly5_if #(parameter int DATA_W = poly5_pkg::DEF_DATA_W);
  logic                         ap_start;
  logic                         ap_idle;
  logic                         ap_ready;
  logic                         ap_done;
  logic signed [DATA_W-1:0]     x;
  logic [5:0][DATA_W-1:0]       coef;
  logic signed [DATA_W-1:0]     ap_return;
  logic signed [DATA_W-1:0]     mul_din0;
  logic signed [DATA_W-1:0]     mul_din1;
  logic signed [2*DATA_W-1:0]   mul_dout;

  modport master (
    output ap_start, x, coef, mul_dout,
    input  ap_idle, ap_ready, ap_done, ap_return, mul_din0, mul_din1
  );

  modport slave (
    input  ap_start, x, coef, mul_dout,
    output ap_idle, ap_ready, ap_done, ap_return, mul_din0, mul_din1
  );
endinterface

// File: rtl/poly5_shift_add.sv
// One Horner step after the multiply: rescale the product, add c_k, reduce to DATA_W.
// POLY5_SAT_EN selects clamping of both the rescaled product and the sum; default wraps.
module poly5_shift_add
  import poly5_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [2*DATA_W-1:0] mul_dout,
  input  logic signed [DATA_W-1:0]   c,
  output logic signed [DATA_W-1:0]   res
);
  localparam int PW = 2 * DATA_W;
`ifdef POLY5_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic signed [PW-1:0] s;
  logic signed [64:0]   s_ext, s_use, c_ext, sum;
  logic signed [63:0]   s_red, r;
  logic                 unused_hi;

  always_comb begin
    // Arithmetic shift floors toward -inf, matching the Q-format rescale.
    s     = mul_dout >>> FRAC_W;
    s_ext = {{(65 - PW){s[PW-1]}}, s};
    s_red = sat_wrap(s_ext, DATA_W, SAT);
    s_use = SAT ? {{(65 - DATA_W){s_red[DATA_W-1]}}, s_red[DATA_W-1:0]} : s_ext;
    c_ext = {{(65 - DATA_W){c[DATA_W-1]}}, c};
    sum   = s_use + c_ext;
    r     = sat_wrap(sum, DATA_W, SAT);
    res   = r[DATA_W-1:0];
  end

  assign unused_hi = ^{s_red, r[63:DATA_W]};
endmodule

// File: rtl/poly5_horner_ctrl.sv
// Horner-scheme controller for a 5th-degree Q-format polynomial on one shared multiplier.
// Optional POLY5_SAT_EN build saturates each step instead of wrapping (see poly5_shift_add).
module poly5_horner_ctrl
  import poly5_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic   ap_clk,
  input  logic   ap_rst,
  poly5_if.slave bus
);
  state_t                   state, nxt;
  coef_idx_t                k;
  logic signed [DATA_W-1:0] acc, x_q, ret_q, res;
  logic [5:0][DATA_W-1:0]   coef_q;
  logic                     cap, step;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.ap_start) nxt = STEP;
      STEP:    if (k == '0) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced to their reset values while ap_rst is high.
  always_comb begin
    bus.ap_idle  = ap_rst || (state == IDLE);
    bus.ap_ready = !ap_rst && (state == IDLE) && bus.ap_start;
    bus.ap_done  = !ap_rst && (state == DONE);
    cap          = bus.ap_ready;
    step         = !ap_rst && (state == STEP);
  end

  poly5_shift_add #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sa (
    .mul_dout (bus.mul_dout),
    .c        (coef_q[k]),
    .res      (res)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc    <= '0;
      x_q    <= '0;
      coef_q <= '0;
      k      <= '0;
      ret_q  <= '0;
    end else if (cap) begin
      x_q    <= bus.x;
      coef_q <= bus.coef;
      acc    <= bus.coef[5];
      k      <= K_FIRST;
    end else if (step) begin
      acc <= res;
      // Result is captured on the last step so it is valid on entry to DONE.
      if (k == '0) ret_q <= res;
      else         k     <= k - coef_idx_t'(1);
    end
  end

  assign bus.mul_din0  = acc;
  assign bus.mul_din1  = x_q;
  assign bus.ap_return = ret_q;
endmodule

// File: tb/tb_poly5_horner_ctrl.sv
// Directed bench for poly5_horner_ctrl; models the shared 16x16 signed multiplier.
// Expected results are hand-computed Q8.8 values; POLY5_SAT_EN selects the saturating expectations.
module tb_poly5_horner_ctrl;
  logic ap_clk;
  logic ap_rst;
  int   errors = 0;
  int   checks = 0;

`ifdef POLY5_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  poly5_if #(.DATA_W(16)) bus();

  poly5_horner_ctrl #(.DATA_W(16), .FRAC_W(8)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  assign bus.mul_dout = {{16{bus.mul_din0[15]}}, bus.mul_din0} *
                        {{16{bus.mul_din1[15]}}, bus.mul_din1};

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Pulses ap_start for one cycle, scrambles inputs after capture, measures latency.
  task automatic run_eval(input logic [15:0] xv, input logic [5:0][15:0] cv,
                          output logic rdy, output int lat, output logic [15:0] res,
                          output logic idle_after);
    bus.x = xv;
    bus.coef = cv;
    bus.ap_start = 1'b1;
    #1 rdy = bus.ap_ready;
    tick();
    bus.ap_start = 1'b0;
    bus.x = ~xv;
    bus.coef = ~cv;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      if (bus.ap_done) begin
        lat = i;
        res = bus.ap_return;
      end
      tick();
    end
    idle_after = bus.ap_idle;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.ap_start = 1'b1;
    bus.x = 16'h1111;
    bus.coef = '1;
    repeat (3) tick();
    checks++;
    if (bus.ap_ready !== 1'b0 || bus.ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: ready=%b idle=%b, want ready=0 idle=1", bus.ap_ready, bus.ap_idle);
    end
    ap_rst = 1'b0;
    bus.ap_start = 1'b0;
    tick();
    checks++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: idle=%b ready=%b done=%b, want 1 0 0",
               bus.ap_idle, bus.ap_ready, bus.ap_done);
    end
    checks++;
    if (bus.ap_return !== 16'h0 || bus.mul_din0 !== 16'h0 || bus.mul_din1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: ret=%h din0=%h din1=%h, want 0 0 0",
               bus.ap_return, bus.mul_din0, bus.mul_din1);
    end
  endtask

  task automatic test_unity();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res;
    run_eval(16'h0100, {6{16'h0100}}, rdy, lat, res, idle_after);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL unity_ready: got %b want 1", rdy); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL unity_latency: got %0d want 6", lat); end
    checks++;
    if (res !== 16'h0600) begin errors++; $display("FAIL unity_result: got %h want 0600", res); end
    checks++;
    if (idle_after !== 1'b1) begin errors++; $display("FAIL unity_idle: got %b want 1", idle_after); end
    repeat (3) tick();
    checks++;
    if (bus.ap_return !== 16'h0600 || bus.ap_done !== 1'b0) begin
      errors++;
      $display("FAIL unity_hold: ret=%h done=%b, want 0600 0", bus.ap_return, bus.ap_done);
    end
  endtask

  task automatic test_x_zero();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res;
    run_eval(16'h0000, {16'h7ABC, 16'h8001, 16'h0F0F, 16'hC3C3, 16'h5A5A, 16'h1234},
             rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'h1234 || lat != 6) begin
      errors++;
      $display("FAIL x_zero: got %h lat %0d, want 1234 lat 6", res, lat);
    end
  endtask

  task automatic test_sign();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res;
    run_eval(16'hFF00, {16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'hFF00) begin errors++; $display("FAIL neg_one: got %h want FF00", res); end
    run_eval(16'h0200, {16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'h2000) begin errors++; $display("FAIL two_pow5: got %h want 2000", res); end
  endtask

  task automatic test_overflow();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res, exp;
    run_eval(16'h0400, {16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, rdy, lat, res, idle_after);
    exp = SAT ? 16'h7FFF : 16'h0000;
    checks++;
    if (res !== exp) begin errors++; $display("FAIL four_pow5: got %h want %h", res, exp); end
    run_eval(16'h0100, {16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001}, rdy, lat, res, idle_after);
    exp = SAT ? 16'h7FFF : 16'h8000;
    checks++;
    if (res !== exp) begin errors++; $display("FAIL add_pos_ovf: got %h want %h", res, exp); end
    run_eval(16'h0100, {16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF}, rdy, lat, res, idle_after);
    exp = SAT ? 16'h8000 : 16'h7FFF;
    checks++;
    if (res !== exp) begin errors++; $display("FAIL add_neg_ovf: got %h want %h", res, exp); end
  endtask

  task automatic test_floor();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res;
    // -1/256 * 0.5 floors back to -1/256 on every step.
    run_eval(16'h0080, {16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'hFFFF) begin errors++; $display("FAIL floor_shift: got %h want FFFF", res); end
  endtask

  task automatic test_mixed();
    logic rdy, idle_after;
    int lat;
    logic [15:0] res;
    run_eval(16'h0180, {16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'h0798) begin errors++; $display("FAIL x1p5_pow5: got %h want 0798", res); end
    run_eval(16'h0200, {16'h0, 16'h0, 16'h0, 16'h0100, 16'hFE00, 16'h0300}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'h0300) begin errors++; $display("FAIL quadratic: got %h want 0300", res); end
  endtask

  task automatic test_mid_reset();
    logic rdy, idle_after, seen_done;
    int lat;
    logic [15:0] res;
    bus.x = 16'h0100;
    bus.coef = {6{16'h0100}};
    bus.ap_start = 1'b1;
    #1;
    checks++;
    if (bus.ap_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.ap_ready); end
    tick();
    bus.ap_start = 1'b0;
    tick();
    tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    checks++;
    if (bus.ap_idle !== 1'b1 || bus.ap_return !== 16'h0 || bus.mul_din0 !== 16'h0) begin
      errors++;
      $display("FAIL midrst_state: idle=%b ret=%h din0=%h, want 1 0000 0000",
               bus.ap_idle, bus.ap_return, bus.mul_din0);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ap_done) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got done=1 want 0"); end
    run_eval(16'h0200, {6{16'h0080}}, rdy, lat, res, idle_after);
    checks++;
    if (res !== 16'h1F80 || lat != 6) begin
      errors++;
      $display("FAIL midrst_restart: got %h lat %0d, want 1F80 lat 6", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int caps[$];
    int dones[$];
    logic [15:0] got[$];
    int exp_cap[3] = '{0, 7, 14};
    int exp_done[3] = '{6, 13, 20};
    logic [15:0] exp_res[3] = '{16'h0060, 16'h1F80, 16'h05A0};
    logic [15:0] cc;
    int overlap = 0;
    int a, d;
    logic [15:0] g;
    for (int i = 0; i < 24; i++) begin
      bus.ap_start = (i < 20);
      bus.x = (i % 2 == 0) ? 16'h0100 : 16'h0200;
      cc = (i % 2 == 0) ? 16'((i + 1) * 16) : 16'h0080;
      bus.coef = {6{cc}};
      #1;
      if (bus.ap_ready && bus.ap_done) overlap++;
      if (bus.ap_ready) caps.push_back(i);
      if (bus.ap_done) begin
        dones.push_back(i);
        got.push_back(bus.ap_return);
      end
      tick();
    end
    bus.ap_start = 1'b0;
    checks++;
    if (caps.size() != 3 || dones.size() != 3 || overlap != 0) begin
      errors++;
      $display("FAIL b2b_counts: caps=%0d dones=%0d overlap=%0d, want 3 3 0",
               caps.size(), dones.size(), overlap);
    end
    for (int j = 0; j < 3; j++) begin
      a = (j < caps.size()) ? caps[j] : -1;
      d = (j < dones.size()) ? dones[j] : -1;
      g = (j < got.size()) ? got[j] : 16'hxxxx;
      checks++;
      if (a != exp_cap[j] || d != exp_done[j]) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: capture %0d done %0d, want %0d %0d",
                 j, a, d, exp_cap[j], exp_done[j]);
      end
      checks++;
      if (g !== exp_res[j]) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got %h want %h", j, g, exp_res[j]);
      end
    end
  endtask

  initial begin
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    bus.x = '0;
    bus.coef = '0;
    test_reset();
    test_unity();
    test_x_zero();
    test_sign();
    test_overflow();
    test_floor();
    test_mixed();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
